// File: rtl/led_scan_driver_pkg.sv
// Shared constants, frame type and scan-state encoding for the LED matrix scan driver.
package led_pkg;

   localparam int ROWS      = 8;
   localparam int COLS      = 8;
   localparam int BPP       = 3;
   localparam int ROW_BITS  = 24;
   localparam int WORD_BITS = 32;

   typedef logic [ROWS-1:0][ROW_BITS-1:0] frame_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SHIFT,
      ST_LATCH,
      ST_DWELL
   } scan_state_e;

   // Serial word for one row: row-select one-hot in the top byte, pixel colors below.
   function automatic logic [WORD_BITS-1:0] row_word(input logic [2:0]          row,
                                                     input logic [ROW_BITS-1:0] color,
                                                     input logic                invert);
      logic [ROWS-1:0] onehot;
      onehot      = '0;
      onehot[row] = 1'b1;
      return {onehot, invert ? ~color : color};
   endfunction

endpackage

// File: rtl/led_scan_driver_if.sv
// Frame handoff channel: a source offers a full frame, the scan driver accepts it when its pending buffer is free.
interface led_scan_driver_if;
   import led_pkg::*;

   frame_t frame_in;
   logic   frame_valid;
   logic   frame_ready;

   modport master (output frame_in, output frame_valid, input  frame_ready);
   modport slave  (input  frame_in, input  frame_valid, output frame_ready);

endinterface

// File: rtl/led_scan_driver_shift_out.sv
// 32-bit parallel-load serializer: MSB first, each bit held for a low then a high sh_cp phase of CLK_DIV cycles.
module led_shift_out
   import led_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WORD_BITS-1:0] word,
   output logic                 done,
   output logic                 sh_cp,
   output logic                 ds
);

   localparam int             DW       = $clog2(CLK_DIV + 1);
   localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);

   logic [WORD_BITS-1:0] shreg;
   logic [4:0]           bit_cnt;
   logic [DW-1:0]        div_cnt;
   logic                 busy;

   assign ds = shreg[WORD_BITS-1];

   // Combinational so the FSM can raise st_cp on the same edge that ends the last high phase.
   assign done = busy && sh_cp && (div_cnt == DIV_LAST) && (bit_cnt == 5'd31);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg   <= '0;
         bit_cnt <= '0;
         div_cnt <= '0;
         busy    <= 1'b0;
         sh_cp   <= 1'b0;
      end else if (start) begin
         shreg   <= word;
         bit_cnt <= '0;
         div_cnt <= '0;
         busy    <= 1'b1;
         sh_cp   <= 1'b0;
      end else if (busy) begin
         if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (!sh_cp) begin
               sh_cp <= 1'b1;
            end else begin
               sh_cp <= 1'b0;
               if (bit_cnt == 5'd31) begin
                  busy <= 1'b0;
               end else begin
                  bit_cnt <= bit_cnt + 5'd1;
                  shreg   <= {shreg[WORD_BITS-2:0], 1'b0};
               end
            end
         end else begin
            div_cnt <= div_cnt + DW'(1);
         end
      end
   end

endmodule

// File: rtl/led_scan_driver.sv
// Row-scanning driver for an 8x8 RGB matrix behind a 74HC595-style chain; double-buffered so frames swap only at the row-7 wrap.
module led_scan_driver
   import led_pkg::*;
#(
   parameter int CLK_DIV          = 4,
   parameter int DWELL            = 1000,
   parameter int COLOR_ACTIVE_LOW = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   led_scan_driver_if.slave   fif,
   output logic               sh_cp,
   output logic               st_cp,
   output logic               ds,
   output logic [2:0]         row_idx,
   output logic               frame_done
);

   localparam int            CNT_MAX    = (CLK_DIV > DWELL) ? CLK_DIV : DWELL;
   localparam int            CW         = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] LATCH_LAST = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);

   scan_state_e          state;
   frame_t               active;
   frame_t               pending;
   logic                 pend_full;
   logic [CW-1:0]        cnt;
   logic                 start;
   logic                 shift_done;
   logic [WORD_BITS-1:0] word;
   logic                 capture;

   assign fif.frame_ready = ~pend_full;
   assign capture         = fif.frame_valid && !pend_full;
   assign start           = (state == ST_LOAD);
   assign word            = row_word(row_idx, active[row_idx], COLOR_ACTIVE_LOW != 0);

   led_shift_out #(.CLK_DIV(CLK_DIV)) u_shift (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .word  (word),
      .done  (shift_done),
      .sh_cp (sh_cp),
      .ds    (ds)
   );

   // Capture and swap never coincide: capture needs pending empty, a swap needs it full.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         active     <= '0;
         pending    <= '0;
         pend_full  <= 1'b0;
         row_idx    <= 3'd0;
         st_cp      <= 1'b0;
         frame_done <= 1'b0;
         cnt        <= '0;
      end else begin
         frame_done <= 1'b0;
         if (capture) begin
            pending   <= fif.frame_in;
            pend_full <= 1'b1;
         end
         case (state)
            ST_IDLE: begin
               if (pend_full) begin
                  active    <= pending;
                  pend_full <= 1'b0;
                  row_idx   <= 3'd0;
                  state     <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               state <= ST_SHIFT;
            end
            ST_SHIFT: begin
               if (shift_done) begin
                  st_cp <= 1'b1;
                  cnt   <= '0;
                  state <= ST_LATCH;
               end
            end
            ST_LATCH: begin
               if (cnt == LATCH_LAST) begin
                  st_cp <= 1'b0;
                  cnt   <= '0;
                  state <= ST_DWELL;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_DWELL: begin
               if (cnt == DWELL_LAST) begin
                  cnt   <= '0;
                  state <= ST_LOAD;
                  if (row_idx != 3'd7) begin
                     row_idx <= row_idx + 3'd1;
                  end else begin
                     row_idx    <= 3'd0;
                     frame_done <= 1'b1;
                     if (pend_full) begin
                        active    <= pending;
                        pend_full <= 1'b0;
                     end
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/led_scan_driver.md
LED_SCAN_DRIVER -- requirements
Module: led_scan_driver

Interface
REQ-001 Parameter CLK_DIV, default 4: each half-period of sh_cp and the st_cp high time, in clk cycles; legal range ≥1.
REQ-002 Parameter DWELL, default 1000: clk cycles a latched row is held before the next row is loaded; legal range ≥1.
REQ-003 Parameter COLOR_ACTIVE_LOW, default 1: 1 = color bits inverted on ds (common-anode matrix).
REQ-004 Port clk, input, 1: single system clock; all logic on its rising edge.
REQ-005 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 Port frame_in, input, [7:0][23:0]: translated frame; row r = frame_in[r]; 8 pixels × 3-bit RGB per row.
REQ-007 Port frame_valid, input, 1: frame_in holds a frame to display.
REQ-008 Port frame_ready, output, 1: the pending buffer is empty.
REQ-009 Port sh_cp, output, 1: shift-register clock; ds is sampled externally on its rising edge.
REQ-010 Port st_cp, output, 1: storage-latch clock to the shift-register chain.
REQ-011 Port ds, output, 1: serial data.
REQ-012 Port row_idx, output, 3: row currently being shifted or displayed.
REQ-013 Port frame_done, output, 1: one-cycle pulse at the end of row 7's dwell.

Function
REQ-014 Handshake: the frame is captured into the pending buffer on the clk edge where frame_valid && frame_ready; frame_ready drops the next cycle.
REQ-015 frame_valid while frame_ready=0 is ignored; the frame is not captured, and the source holds frame_in.
REQ-016 State machine: IDLE → LOAD → SHIFT → LATCH → DWELL → LOAD, or back to IDLE as defined in REQ-021.
REQ-017 IDLE: while pending is empty, outputs stay low; when pending is full, pending is copied to the active buffer, pending is cleared, row_idx=0, and the state goes to LOAD.
REQ-018 LOAD (1 cycle): word = {onehot(row_idx)[7:0], color[23:0]}, where color = active[row_idx], inverted when COLOR_ACTIVE_LOW=1.
REQ-019 SHIFT: 32 bits go out MSB (word[31]) first; per bit, ds is stable, sh_cp is low for CLK_DIV cycles, then high for CLK_DIV cycles. Total 64·CLK_DIV cycles.
REQ-020 LATCH: sh_cp=0 and st_cp=1 for CLK_DIV cycles; ds holds its last value.
REQ-021 DWELL: st_cp=0 for DWELL cycles, then:
- If row_idx<7: row_idx increments and the state goes to LOAD.
- If row_idx=7: frame_done=1 for one cycle and row_idx wraps to 0.
- At that wrap, if pending is full, pending is swapped into active and cleared.
- Otherwise the active frame is rescanned; the state goes to LOAD.
REQ-022 Row period = 1 + 64·CLK_DIV + CLK_DIV + DWELL cycles; a new frame is applied only at the row-7→row-0 boundary, so frames never tear.
REQ-023 frame_ready rises the cycle after any swap that empties pending.
REQ-024 row_idx updates only in the cycle that enters LOAD.

Reset
REQ-025 While rst_n=0, the following are cleared:
- sh_cp, st_cp, ds, frame_done, row_idx → 0
- frame_ready → 1
- state → IDLE
- active and pending buffers → 0
REQ-026 Reset asserted mid-SHIFT or mid-DWELL aborts immediately with no st_cp pulse; after release, the block waits in IDLE for a new frame.

Structure
REQ-027 Shared package led_pkg holds:
- constants ROWS=8, COLS=8, BPP=3, ROW_BITS=24, WORD_BITS=32
- typedef frame_t (logic [7:0][23:0])
- the scan-state enum
REQ-028 The serializer (a 32-bit parallel-load shifter with the CLK_DIV divider producing sh_cp/ds) is one sub-module, led_shift_out, with start/done handshake to the top FSM.

Verification
REQ-029 CLK_DIV=2, DWELL=8, COLOR_ACTIVE_LOW=0: load frame rows {7:FFFFFF, 3:FFFE00, 2:B6DB6D, others 0}.
- -> the 32 sampled ds bits per row are {onehot, row} (e.g. row 2 = 0x04B6DB6D).
- -> st_cp pulse every 139 cycles; frame_done every 1112 cycles.
REQ-030 Same frame with COLOR_ACTIVE_LOW=1 -> row 7 shifts 0x80000000 and row 2 shifts 0x04492492.
REQ-031 Second frame offered mid-scan -> captured immediately (ready 1→0); displayed starting the row 0 after frame_done; a third frame is held off until that swap.
REQ-032 No second frame -> row_idx wraps 7→0 and the same active data is rescanned with frame_ready=1.
REQ-033 rst_n pulsed low during SHIFT of row 4 -> all outputs 0 within the reset assertion; no st_cp; IDLE with frame_ready=1 until the next frame_valid.
REQ-034 CLK_DIV=1, DWELL=1 boundary -> sh_cp toggles every cycle; row period 67 cycles; no bit lost or duplicated.
